echo_delay_effect: RTL and testbench
====================================

// Module: echo_delay_effect
// PURPOSE
//  Stereo feedback-echo stage between I2S receive and I2S transmit; occupies the effect_controler slot.
//  Captures each received L/R pair once per word-select frame and stores output history in a circular RAM.
//  Emits y = sat(x + (delayed_y >>> i_decay)); i_enable=0 gives registered dry bypass.
//  Same mclk domain as the transceiver.
// PARAMETERS
//  d_width  24  signed PCM sample width, two's complement, per channel
//  addr_w   12  RAM address width; depth = 2**addr_w frames (4096 = 92.9 ms at 44.1 kHz)
// PORTS
//  mclk       in   1        master clock, all logic on rising edge
//  reset_n    in   1        asynchronous active-low reset
//  ws         in   1        word select from transceiver, mclk-synchronous
//  i_l_data   in   d_width  left sample received
//  i_r_data   in   d_width  right sample received
//  i_enable   in   1        1 = echo mix, 0 = bypass
//  i_delay    in   addr_w   echo delay in frames; 0 means 2**addr_w
//  i_decay    in   3        feedback attenuation, arithmetic right shift 0..7
//  o_l_data   out  d_width  left sample to transmit
//  o_r_data   out  d_width  right sample to transmit
//  o_valid    out  1        one-cycle pulse when o_l/o_r update
//  o_overrun  out  1        sticky: frame event arrived while FSM busy
// BEHAVIOUR
//  Reset values
//   - All outputs 0, FSM IDLE, wr_ptr 0, fill_cnt 0, ws_q 0.
//   - RAM is not cleared; stale contents are masked by fill_cnt.
//  Frame event: ws_q==1 && ws==0 (ws falling edge, registered ws_q).
//  FSM (one step per cycle):
//   IDLE -> RD on event.
//    Latch i_l_data, i_r_data, i_enable, i_delay, i_decay.
//    Inputs are sampled only at the event; changes between events have no effect.
//   RD   -> WAIT: rd_addr = wr_ptr - delay (mod depth, wraps naturally; delay 0 reads wr_ptr).
//   WAIT -> MIX: 1-cycle synchronous RAM read latency.
//   MIX  -> WR
//    d = (fill_cnt >= eff_delay) ? ram_q : 0, where eff_delay = (delay==0) ? depth : delay.
//    Per channel: sum = sext(x) + (sext(d) >>> decay), computed at d_width+1 bits.
//    Saturate the sum to [-2**(d_width-1), 2**(d_width-1)-1].
//    Result y = enable ? sat : x.
//    o_l_data/o_r_data <= y in this cycle; o_valid = 1 for this cycle.
//   WR   -> IDLE
//    ram[wr_ptr] <= {y_l, y_r}; wr_ptr <= wr_ptr+1 (wraps at depth).
//    fill_cnt <= min(fill_cnt+1, depth); fill_cnt is addr_w+1 bits and saturates.
//  Latency: event seen at edge E; outputs and o_valid at E+3; write at E+4.
//  Bypass still writes x, so enabling later yields a clean echo of recent input.
//  Event while FSM != IDLE
//   - Event is dropped and o_overrun <= 1.
//   - Cannot occur at 64 sclk x 4 mclk = 256 cycles per frame.
//  Outputs hold their values between o_valid pulses.
//  Reset asserted mid-operation: immediate return to reset state; any pending RAM write is lost.
// STRUCTURE
//  Shared include audio_defs.vh:
//   - D_WIDTH default.
//   - SAT_MAX/SAT_MIN localparams as functions of d_width.
//   - FSM state encodings IDLE/RD/WAIT/MIX/WR (3-bit).
//  Sub-module echo_ram
//   - Simple dual-port, 2*d_width wide, 2**addr_w deep.
//   - Registered read, no reset; infers BRAM.
//  Top-level effect_controler swap: connect mclk, reset_n, ws; hold i_enable from a debounced switch.
// TESTING (bench with addr_w=4, depth 16; frames driven as ws toggling every 128 mclk)
//  1. Bypass: enable=0, L=0x123456, R=0xFEDCBA -> o_valid 3 cycles after ws fall, outputs equal inputs.
//  2. Impulse
//     - Stimulus: enable=1, delay=3, decay=1, L=0x400000 in frame 0, then 0.
//     - Response: L out 0x400000 at frame 0, 0x200000 at frame 3, 0x100000 at frame 6; R stays 0.
//  3. Saturation
//     - Stimulus: decay=0, delay=1, L constant 0x600000.
//     - Response: frame 1 output clamps to 0x7FFFFF; negative case -0x600000 clamps to 0x800000.
//  4. Fill masking and delay 0
//     - Stimulus: RAM preloaded with garbage, then reset; enable=1, delay=0, impulse at frame 0.
//     - Response: outputs 0 for frames 1..15; echo appears at frame 16.
//  5. Reset mid-operation
//     - Stimulus: reset_n low during MIX.
//     - Response: outputs 0, wr_ptr 0, no o_valid; next frame behaves as first frame after reset.
//  6. Overrun: force ws edges 2 cycles apart -> second event dropped, o_overrun=1 until reset.

Source files
------------

// File: rtl/echo_delay_effect_pkg.sv
// echo_delay_effect_pkg: default widths and FSM states shared by the echo stage.
package echo_delay_effect_pkg;
   localparam int D_WIDTH = 24;
   localparam int ADDR_W  = 12;
   typedef enum logic [2:0] {IDLE, RD, WAIT, MIX, WR} state_e;
endpackage

// File: rtl/echo_delay_effect_ram.sv
// echo_delay_effect_ram: simple dual-port history RAM with registered read, no reset so it maps to block RAM.
module echo_delay_effect_ram #(
   parameter int width  = 48,
   parameter int addr_w = 12
) (
   input  logic              mclk,
   input  logic              we_i,
   input  logic [addr_w-1:0] waddr_i,
   input  logic [width-1:0]  wdata_i,
   input  logic              re_i,
   input  logic [addr_w-1:0] raddr_i,
   output logic [width-1:0]  rdata_o
);
   logic [width-1:0] mem_q [2**addr_w];
   logic [width-1:0] rdata_q;
   always_ff @(posedge mclk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      if (re_i) rdata_q <= mem_q[raddr_i];
   end
   assign rdata_o = rdata_q;
endmodule

// File: rtl/echo_delay_effect.sv
// echo_delay_effect: stereo feedback echo, y = sat(x + (delayed_y >>> decay)), one frame per ws falling edge.
module echo_delay_effect
   import echo_delay_effect_pkg::*;
#(
   parameter int d_width = D_WIDTH,
   parameter int addr_w  = ADDR_W
) (
   input  logic               mclk,
   input  logic               reset_n,
   input  logic               ws,
   input  logic [d_width-1:0] i_l_data,
   input  logic [d_width-1:0] i_r_data,
   input  logic               i_enable,
   input  logic [addr_w-1:0]  i_delay,
   input  logic [2:0]         i_decay,
   output logic [d_width-1:0] o_l_data,
   output logic [d_width-1:0] o_r_data,
   output logic               o_valid,
   output logic               o_overrun
);
   localparam logic [addr_w:0] DEPTH = {1'b1, {addr_w{1'b0}}};
   state_e              state_q, state_d;
   logic                ws_q, en_q, valid_q, ovr_q;
   logic [d_width-1:0]  x_l_q, x_r_q, o_l_q, o_r_q, y_l, y_r, d_l, d_r;
   logic [addr_w-1:0]   delay_q, wr_ptr_q;
   logic [2:0]          decay_q;
   logic [addr_w:0]     fill_q, eff_delay;
   logic [2*d_width-1:0] ram_q;
   logic                ev;

   function automatic logic [d_width-1:0] mix_ch(input logic [d_width-1:0] x,
                                                  input logic [d_width-1:0] d,
                                                  input logic [2:0] sh);
      logic signed [d_width:0] s;
      s = $signed({x[d_width-1], x}) + ($signed({d[d_width-1], d}) >>> sh);
      // the two top bits disagree exactly when the sum left the d_width range
      return (s[d_width] != s[d_width-1]) ? {s[d_width], {(d_width-1){~s[d_width]}}} : s[d_width-1:0];
   endfunction

   assign ev        = ws_q & ~ws;
   assign eff_delay = (delay_q == '0) ? DEPTH : {1'b0, delay_q};
   assign d_l       = (fill_q >= eff_delay) ? ram_q[2*d_width-1:d_width] : '0;
   assign d_r       = (fill_q >= eff_delay) ? ram_q[d_width-1:0] : '0;
   assign y_l       = en_q ? mix_ch(x_l_q, d_l, decay_q) : x_l_q;
   assign y_r       = en_q ? mix_ch(x_r_q, d_r, decay_q) : x_r_q;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    state_d = ev ? RD : IDLE;
         RD:      state_d = WAIT;
         WAIT:    state_d = MIX;
         MIX:     state_d = WR;
         WR:      state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge mclk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         ws_q     <= 1'b0;
         en_q     <= 1'b0;
         valid_q  <= 1'b0;
         ovr_q    <= 1'b0;
         x_l_q    <= '0;
         x_r_q    <= '0;
         o_l_q    <= '0;
         o_r_q    <= '0;
         delay_q  <= '0;
         decay_q  <= '0;
         wr_ptr_q <= '0;
         fill_q   <= '0;
      end else begin
         state_q <= state_d;
         ws_q    <= ws;
         valid_q <= (state_q == MIX);
         if (ev && state_q != IDLE) ovr_q <= 1'b1;
         if (ev && state_q == IDLE) begin
            x_l_q   <= i_l_data;
            x_r_q   <= i_r_data;
            en_q    <= i_enable;
            delay_q <= i_delay;
            decay_q <= i_decay;
         end
         if (state_q == MIX) begin
            o_l_q <= y_l;
            o_r_q <= y_r;
         end
         if (state_q == WR) begin
            wr_ptr_q <= wr_ptr_q + addr_w'(1);
            fill_q   <= (fill_q == DEPTH) ? fill_q : fill_q + (addr_w+1)'(1);
         end
      end
   end

   // o_l_q/o_r_q double as the write-back data: bypass frames store dry x too
   echo_delay_effect_ram #(.width(2*d_width), .addr_w(addr_w)) u_ram (
      .mclk    (mclk),
      .we_i    (state_q == WR),
      .waddr_i (wr_ptr_q),
      .wdata_i ({o_l_q, o_r_q}),
      .re_i    (state_q == RD),
      .raddr_i (wr_ptr_q - delay_q),
      .rdata_o (ram_q)
   );

   assign o_l_data  = o_l_q;
   assign o_r_data  = o_r_q;
   assign o_valid   = valid_q;
   assign o_overrun = ovr_q;
endmodule

// File: tb/tb_echo_delay_effect.sv
// tb_echo_delay_effect: table vectors, hand sequences and random frames against a frame-history model.
module tb_echo_delay_effect;
   logic        mclk = 1'b0, reset_n = 1'b0, ws = 1'b1;
   logic [23:0] i_l_data = '0, i_r_data = '0;
   logic        i_enable = 1'b0;
   logic [3:0]  i_delay = '0;
   logic [2:0]  i_decay = '0;
   logic [23:0] o_l_data, o_r_data;
   logic        o_valid, o_overrun;
   int          n_chk = 0, n_fail = 0;
   logic [23:0] hl[$], hr[$];

   typedef struct {
      logic        rst;
      logic [23:0] l, r;
      logic        en;
      logic [3:0]  dly;
      logic [2:0]  dec;
      logic [23:0] el, er;
   } vec_t;
   vec_t tbl[$];

   echo_delay_effect #(.d_width(24), .addr_w(4)) dut (
      .mclk(mclk), .reset_n(reset_n), .ws(ws),
      .i_l_data(i_l_data), .i_r_data(i_r_data), .i_enable(i_enable),
      .i_delay(i_delay), .i_decay(i_decay),
      .o_l_data(o_l_data), .o_r_data(o_r_data),
      .o_valid(o_valid), .o_overrun(o_overrun)
   );

   always #5 mclk = ~mclk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   function automatic logic [23:0] mix1(input logic [23:0] x, input logic [23:0] d, input logic en, input logic [2:0] dec);
      int s, dv;
      if (!en) return x;
      s  = $signed(x);
      dv = $signed(d);
      s  = s + (dv >>> dec);
      if (s > 8388607) s = 8388607;
      if (s < -8388608) s = -8388608;
      return s[23:0];
   endfunction

   task automatic model(input logic [23:0] l, r, input logic en, input logic [3:0] dly, input logic [2:0] dec,
                        output logic [23:0] el, er);
      int eff, n;
      logic [23:0] dl, dr;
      eff = (dly == 0) ? 16 : int'(dly);
      n   = hl.size();
      dl  = (n >= eff) ? hl[n-eff] : 24'h0;
      dr  = (n >= eff) ? hr[n-eff] : 24'h0;
      el  = mix1(l, dl, en, dec);
      er  = mix1(r, dr, en, dec);
   endtask

   task automatic model_reset();
      hl.delete();
      hr.delete();
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      ws = 1'b1;
      repeat (3) @(posedge mclk);
      #1 reset_n = 1'b1;
      repeat (2) @(posedge mclk);
   endtask

   task automatic run_frame(input logic [23:0] l, r, input logic en, input logic [3:0] dly, input logic [2:0] dec,
                            input logic [23:0] el, er, input string tag);
      int vat, np;
      @(posedge mclk); #1;
      i_l_data = l; i_r_data = r; i_enable = en; i_delay = dly; i_decay = dec;
      ws = 1'b0;
      vat = -1; np = 0;
      for (int c = 1; c <= 8; c++) begin
         @(posedge mclk); #1;
         if (c == 1) begin
            i_l_data = 24'($urandom); i_r_data = 24'($urandom);
            i_enable = 1'($urandom); i_delay = 4'($urandom); i_decay = 3'($urandom);
         end
         if (o_valid) begin np++; vat = c; end
      end
      chk({tag, " valid_at"}, (np == 1) ? vat : -np, 4);
      chk({tag, " L"}, o_l_data, el);
      chk({tag, " R"}, o_r_data, er);
      repeat (120) @(posedge mclk);
      #1 ws = 1'b1;
      repeat (127) @(posedge mclk);
      chk({tag, " hold"}, {o_valid, o_l_data}, {1'b0, el});
      hl.push_back(el);
      hr.push_back(er);
   endtask

   task automatic rand_frame(input logic en, input string tag);
      logic [23:0] l, r, el, er;
      logic [3:0]  dly;
      logic [2:0]  dec;
      l = 24'($urandom); r = 24'($urandom);
      dly = 4'($urandom); dec = 3'($urandom);
      model(l, r, en, dly, dec, el, er);
      run_frame(l, r, en, dly, dec, el, er, tag);
   endtask

   initial begin
      logic [23:0] el, er;
      int np;
      tbl.push_back('{1, 24'h123456, 24'hFEDCBA, 0, 3, 0, 24'h123456, 24'hFEDCBA});
      tbl.push_back('{1, 24'h400000, 24'h0, 1, 3, 1, 24'h400000, 24'h0});
      tbl.push_back('{0, 24'h0, 24'h0, 1, 3, 1, 24'h0, 24'h0});
      tbl.push_back('{0, 24'h0, 24'h0, 1, 3, 1, 24'h0, 24'h0});
      tbl.push_back('{0, 24'h0, 24'h0, 1, 3, 1, 24'h200000, 24'h0});
      tbl.push_back('{0, 24'h0, 24'h0, 1, 3, 1, 24'h0, 24'h0});
      tbl.push_back('{0, 24'h0, 24'h0, 1, 3, 1, 24'h0, 24'h0});
      tbl.push_back('{0, 24'h0, 24'h0, 1, 3, 1, 24'h100000, 24'h0});
      tbl.push_back('{1, 24'h600000, 24'h0, 1, 1, 0, 24'h600000, 24'h0});
      tbl.push_back('{0, 24'h600000, 24'h0, 1, 1, 0, 24'h7FFFFF, 24'h0});
      tbl.push_back('{0, 24'h600000, 24'h0, 1, 1, 0, 24'h7FFFFF, 24'h0});
      tbl.push_back('{1, 24'hA00000, 24'h0, 1, 1, 0, 24'hA00000, 24'h0});
      tbl.push_back('{0, 24'hA00000, 24'h0, 1, 1, 0, 24'h800000, 24'h0});
      tbl.push_back('{0, 24'hA00000, 24'h0, 1, 1, 0, 24'h800000, 24'h0});

      do_reset();
      chk("reset outputs", {o_valid, o_overrun, o_l_data, o_r_data}, '0);

      foreach (tbl[i]) begin
         if (tbl[i].rst) begin do_reset(); model_reset(); end
         run_frame(tbl[i].l, tbl[i].r, tbl[i].en, tbl[i].dly, tbl[i].dec, tbl[i].el, tbl[i].er,
                   $sformatf("tbl%0d", i));
      end

      // fill the RAM with nonzero history, then reset: delay 0 must not see it
      do_reset(); model_reset();
      for (int f = 0; f < 20; f++) rand_frame(1'b1, $sformatf("fill%0d", f));
      do_reset(); model_reset();
      for (int f = 0; f <= 16; f++) begin
         el = (f == 0 || f == 16) ? 24'h123456 : 24'h0;
         er = (f == 0 || f == 16) ? 24'h654321 : 24'h0;
         run_frame((f == 0) ? 24'h123456 : 24'h0, (f == 0) ? 24'h654321 : 24'h0, 1'b1, 4'd0, 3'd0,
                   el, er, $sformatf("mask%0d", f));
      end

      // reset while the FSM is in MIX
      @(posedge mclk); #1;
      i_l_data = 24'h222222; i_r_data = 24'h333333; i_enable = 1'b1; i_delay = 4'd1; i_decay = 3'd0;
      ws = 1'b0;
      repeat (3) @(posedge mclk);
      #1 reset_n = 1'b0;
      #1 chk("midrst outputs", {o_valid, o_l_data, o_r_data}, '0);
      np = 0;
      repeat (4) begin @(posedge mclk); #1 np += int'(o_valid); end
      chk("midrst no valid", np, 0);
      do_reset(); model_reset();
      run_frame(24'h300000, 24'h0, 1'b1, 4'd2, 3'd1, 24'h300000, 24'h0, "post0");
      run_frame(24'h0, 24'h0, 1'b1, 4'd2, 3'd1, 24'h0, 24'h0, "post1");
      run_frame(24'h0, 24'h0, 1'b1, 4'd2, 3'd1, 24'h180000, 24'h0, "post2");

      do_reset(); model_reset();
      for (int f = 0; f < 60; f++) rand_frame($urandom_range(0, 3) != 0, $sformatf("rnd%0d", f));
      chk("no overrun", o_overrun, 0);

      // two ws falls two cycles apart: the second must be dropped
      do_reset(); model_reset();
      @(posedge mclk); #1;
      i_l_data = 24'h111111; i_r_data = 24'h0; i_enable = 1'b1; i_delay = 4'd1; i_decay = 3'd0;
      ws = 1'b0;
      @(posedge mclk); #1 ws = 1'b1;
      @(posedge mclk); #1 ws = 1'b0;
      np = 0;
      repeat (10) begin @(posedge mclk); #1 np += int'(o_valid); end
      chk("ovr flag", o_overrun, 1);
      chk("ovr pulses", np, 1);
      chk("ovr L", o_l_data, 24'h111111);
      ws = 1'b1;
      repeat (128) @(posedge mclk);
      hl.push_back(24'h111111); hr.push_back(24'h0);
      rand_frame(1'b1, "ovr next");
      chk("ovr sticky", o_overrun, 1);
      do_reset();
      chk("ovr cleared", o_overrun, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
